// File: rtl/dll_ctrl_pkg.sv
// dll_ctrl_pkg: shared states, code width and code limits for the DLL lock controller
package dll_ctrl_pkg;
  localparam int QW = 10;
  localparam logic [QW-1:0] Q_MID = 10'd512;
  localparam logic [QW-1:0] Q_MAX = 10'd1023;
  typedef enum logic [2:0] {IDLE, PDRST, SETTLE, EVAL, TRACK} state_e;
  typedef enum logic {ACQ, TRK} mode_e;
endpackage

// File: rtl/track_filter.sv
// track_filter: counts consecutive same-sign COMP results and requests a one-code step
module track_filter #(
  parameter int TRK_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic comp,
  output logic step_up,
  output logic step_dn
);
  localparam logic [3:0] N = 4'(TRK_N);
  logic [3:0] streak_q, streak_d, run;
  logic sign_q, sign_d;
  // extend the run on an unchanged sign, restart it at 1 on a sign change
  always_comb begin
    run = (streak_q == 4'd0 || comp == sign_q) ? streak_q + 4'd1 : 4'd1;
    step_up = en && run == N && comp;
    step_dn = en && run == N && !comp;
    streak_d = clr ? 4'd0 : !en ? streak_q : (run == N) ? 4'd0 : run;
    sign_d = en ? comp : sign_q;
  end
  // streak and last sign registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
      sign_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      sign_q <= sign_d;
    end
  end
endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: binary-search acquisition of the delay code, then filtered tracking
module dll_lock_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int TRK_N      = 4
) (
  input  logic          CLK_exit,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          COMP,
  output logic          Reset_PD,
  output logic [QW-1:0] Q,
  output logic          busy,
  output logic          locked,
  output logic          sat_err
);
  localparam logic [3:0] SET_LAST = 4'(SETTLE_CYC - 1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [QW-1:0] q_q, q_d;
  logic [3:0] bit_idx_q, bit_idx_d, cnt_q, cnt_d;
  logic sat_q, sat_d, flt_clr, flt_en, step_up, step_dn;

  assign flt_en = state_q == EVAL && mode_q == TRK && !stop;

  track_filter #(.TRK_N(TRK_N)) u_filter (
    .clk(CLK_exit),
    .rst_n(rst_n),
    .clr(flt_clr),
    .en(flt_en),
    .comp(COMP),
    .step_up(step_up),
    .step_dn(step_dn)
  );

  // trial sequencing: stop wins, otherwise PDRST -> SETTLE -> EVAL and the mode decides what EVAL does
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    q_d = q_q;
    bit_idx_d = bit_idx_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    flt_clr = 1'b0;
    if (stop && state_q != IDLE) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start && !stop) begin
          state_d = PDRST;
          mode_d = ACQ;
          q_d = Q_MID;
          bit_idx_d = 4'd9;
          sat_d = 1'b0;
          flt_clr = 1'b1;
        end
        PDRST: begin
          state_d = SETTLE;
          cnt_d = 4'd0;
        end
        SETTLE: begin
          cnt_d = cnt_q + 4'd1;
          state_d = (cnt_q == SET_LAST) ? EVAL : SETTLE;
        end
        EVAL: if (mode_q == ACQ) begin
          q_d[bit_idx_q] = COMP;
          if (bit_idx_q != 4'd0) begin
            q_d[bit_idx_q - 4'd1] = 1'b1;
            bit_idx_d = bit_idx_q - 4'd1;
            state_d = PDRST;
          end else begin
            mode_d = TRK;
            flt_clr = 1'b1;
            state_d = TRACK;
          end
        end else begin
          state_d = TRACK;
          if (step_up) begin
            if (q_q == Q_MAX) sat_d = 1'b1;
            else q_d = q_q + 10'd1;
          end
          if (step_dn) begin
            if (q_q == '0) sat_d = 1'b1;
            else q_d = q_q - 10'd1;
          end
        end
        TRACK: state_d = PDRST;
        default: state_d = IDLE;
      endcase
    end
  end

  // controller state registers
  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= ACQ;
      q_q <= Q_MID;
      bit_idx_q <= 4'd9;
      cnt_q <= 4'd0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      q_q <= q_d;
      bit_idx_q <= bit_idx_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign Reset_PD = state_q == PDRST;
  assign busy = state_q != IDLE;
  assign locked = busy && mode_q == TRK;
  assign sat_err = sat_q;
  assign Q = q_q;
endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: randomized scoreboard bench for the DLL lock controller
module tb_dll_lock_ctrl;
  localparam int S = 4;
  localparam int TN = 4;
  localparam int TP = S + 2;

  typedef struct {
    string name;
    logic [9:0] q;
    logic busy;
    logic locked;
    logic sat;
    logic rpd;
  } exp_t;

  logic CLK_exit = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic comp_drv = 1'b0;
  logic pd_on = 1'b0;
  logic COMP, Reset_PD, busy, locked, sat_err;
  logic [9:0] Q;
  logic [9:0] target = 10'd0;
  logic snap = 1'b0;
  logic done = 1'b0;
  int tmo_n = 0;
  int tmo_seen = 0;
  bit flushed = 1'b0;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [9:0] m_q = 10'd512;
  logic [9:0] sh_q = 10'd512;
  logic m_sat = 1'b0;
  logic sh_sat = 1'b0;
  int m_streak = 0;
  logic m_sign = 1'b0;

  assign COMP = pd_on ? (Q <= target) : comp_drv;

  always #5 CLK_exit = ~CLK_exit;

  dll_lock_ctrl #(.SETTLE_CYC(S), .TRK_N(TN)) dut (
    .CLK_exit(CLK_exit),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .COMP(COMP),
    .Reset_PD(Reset_PD),
    .Q(Q),
    .busy(busy),
    .locked(locked),
    .sat_err(sat_err)
  );

  initial begin
    forever begin
      @(negedge CLK_exit);
      if (tmo_n != tmo_seen) begin
        tmo_seen = tmo_n;
        checks++;
        failures++;
        $display("FAIL timeout: got no Reset_PD pulse within %0d cycles, required one", 4 * TP);
      end
      if (snap || Reset_PD) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got Q=%0d busy=%0b locked=%0b sat_err=%0b Reset_PD=%0b, required no output",
                   Q, busy, locked, sat_err, Reset_PD);
        end else begin
          mon_e = exp_q.pop_front();
          if (Q !== mon_e.q || busy !== mon_e.busy || locked !== mon_e.locked ||
              sat_err !== mon_e.sat || Reset_PD !== mon_e.rpd) begin
            failures++;
            $display("FAIL %s: got Q=%0d busy=%0b locked=%0b sat_err=%0b Reset_PD=%0b, required Q=%0d busy=%0b locked=%0b sat_err=%0b Reset_PD=%0b",
                     mon_e.name, Q, busy, locked, sat_err, Reset_PD,
                     mon_e.q, mon_e.busy, mon_e.locked, mon_e.sat, mon_e.rpd);
          end
        end
      end
      if (done && !flushed) begin
        flushed = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL leftover: got %0d expected outputs never presented, required 0", exp_q.size());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_exit);
    #1;
  endtask

  task automatic push(input string nm, input logic [9:0] q, input logic b, input logic l,
                      input logic s, input logic r);
    exp_t e;
    e.name = nm;
    e.q = q;
    e.busy = b;
    e.locked = l;
    e.sat = s;
    e.rpd = r;
    exp_q.push_back(e);
  endtask

  task automatic expect_now(input string nm, input logic [9:0] q, input logic b, input logic l,
                            input logic s, input logic r);
    push(nm, q, b, l, s, r);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
  endtask

  // trial k of a binary search toward t: bits decided so far come from t, the trial bit is 1
  function automatic logic [9:0] trial_code(input logic [9:0] t, input int k);
    logic [9:0] hi;
    hi = 10'h3FF << (10 - k);
    return (t & hi) | (10'd1 << (9 - k));
  endfunction

  task automatic model_step(input bit c);
    m_streak = (m_streak == 0 || c == m_sign) ? m_streak + 1 : 1;
    m_sign = c;
    if (m_streak == TN) begin
      m_streak = 0;
      if (c) begin
        if (m_q == 10'd1023) m_sat = 1'b1;
        else m_q = m_q + 10'd1;
      end else begin
        if (m_q == 10'd0) m_sat = 1'b1;
        else m_q = m_q - 10'd1;
      end
    end
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    while (Reset_PD !== 1'b1 && n < 4 * TP) begin
      tick(1);
      n++;
    end
    if (Reset_PD !== 1'b1) tmo_n++;
  endtask

  task automatic acquire(input logic [9:0] t);
    target = t;
    pd_on = 1'b1;
    m_q = t;
    m_sat = 1'b0;
    m_streak = 0;
    for (int k = 0; k < 10; k++) push("acq_trial", trial_code(t, k), 1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10 * TP - 1);
    expect_now("pre_lock", trial_code(t, 9), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_now("lock_rise", t, 1'b1, 1'b1, 1'b0, 1'b0);
    sh_q = t;
    sh_sat = 1'b0;
  endtask

  task automatic track(input bit seq[$]);
    pd_on = 1'b0;
    foreach (seq[j]) begin
      push("trk_trial", m_q, 1'b1, 1'b1, m_sat, 1'b1);
      sh_q = m_q;
      sh_sat = m_sat;
      model_step(seq[j]);
      wait_pulse();
      comp_drv = seq[j];
      start = 1'($urandom_range(0, 1));
      tick(1);
    end
    start = 1'b0;
  endtask

  task automatic abort_check(input string nm);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    expect_now(nm, sh_q, 1'b0, 1'b0, sh_sat, 1'b0);
    tick(3);
    expect_now({nm, "_held"}, sh_q, 1'b0, 1'b0, sh_sat, 1'b0);
  endtask

  initial begin
    bit seq[$];
    bit b;
    logic [9:0] t;
    tick(2);
    expect_now("reset_state", 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);

    acquire(10'd300);
    seq = {};
    for (int i = 0; i < 8; i++) seq.push_back(1'b1);
    for (int i = 0; i < 20; i++) seq.push_back(bit'(i % 2 == 0));
    seq.push_back(1'b1);
    track(seq);
    abort_check("stop_track");

    acquire(10'd1023);
    seq = {};
    for (int i = 0; i < 7; i++) seq.push_back(1'b1);
    track(seq);
    rst_n = 1'b0;
    #1;
    expect_now("rst_in_track", 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    expect_now("post_rst_idle", 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    tick(3);
    expect_now("start_stop_idle", 10'd512, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    stop = 1'b0;
    tick(1);

    acquire(10'd0);
    seq = {};
    for (int i = 0; i < 6; i++) seq.push_back(1'b0);
    track(seq);
    abort_check("stop_low_sat");

    t = 10'($urandom_range(0, 1023));
    target = t;
    pd_on = 1'b1;
    for (int k = 0; k <= 24 / TP; k++) push("acq_trial", trial_code(t, k), 1'b1, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(24);
    sh_q = trial_code(t, 24 / TP);
    sh_sat = 1'b0;
    abort_check("stop_acq_c25");

    for (int r = 0; r < 4; r++) begin
      acquire(10'($urandom_range(0, 1023)));
      seq = {};
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 14; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        seq.push_back(b);
      end
      track(seq);
      abort_check("stop_rand");
    end

    done = 1'b1;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
